// File: rtl/rs232_rx_os.sv
// Oversampling RS-232 receiver: glitch-filtered start detection, mid-bit sampling,
// configurable data width, parity and stop bits, with valid strobe and error flags.
module rs232_rx_os #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_data,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 ctrl,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TMid     = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TEnd     = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LastData = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LastStop = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StWaitHigh
    } state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, rs_q;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [3:0]           bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 fe_acc_q, fe_acc_d;
    logic                 pe_acc_q, pe_acc_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ctrl_q, ctrl_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 fe_now;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            sync1_q  <= 1'b1;
            rs_q     <= 1'b1;
            tcnt_q   <= '0;
            bcnt_q   <= '0;
            sh_q     <= '0;
            fe_acc_q <= 1'b0;
            pe_acc_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ctrl_q   <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= rx_data;
            rs_q     <= sync1_q;
            tcnt_q   <= tcnt_d;
            bcnt_q   <= bcnt_d;
            sh_q     <= sh_d;
            fe_acc_q <= fe_acc_d;
            pe_acc_q <= pe_acc_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        bcnt_d   = bcnt_q;
        sh_d     = sh_q;
        fe_acc_d = fe_acc_q;
        pe_acc_d = pe_acc_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ctrl_d   = ctrl_q;
        ferr_d   = ferr_q;
        perr_d   = perr_q;
        fe_now   = fe_acc_q | ~rs_q;

        if (baud_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (!rs_q) begin
                        state_d = StStart;
                        tcnt_d  = '0;
                    end
                end
                StStart: begin
                    // Line must still be low at mid start bit, otherwise it was a glitch.
                    if (tcnt_q == TMid) begin
                        if (!rs_q) begin
                            state_d  = StData;
                            tcnt_d   = '0;
                            bcnt_d   = '0;
                            fe_acc_d = 1'b0;
                            pe_acc_d = 1'b0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (tcnt_q == TEnd) begin
                        tcnt_d = '0;
                        sh_d   = {rs_q, sh_q[DATA_BITS-1:1]};
                        if (bcnt_q == LastData) begin
                            bcnt_d  = '0;
                            state_d = (PARITY_EN != 0) ? StParity : StStop;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                StParity: begin
                    if (tcnt_q == TEnd) begin
                        tcnt_d   = '0;
                        bcnt_d   = '0;
                        pe_acc_d = ((^sh_q) ^ rs_q) != 1'(PARITY_ODD);
                        state_d  = StStop;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (tcnt_q == TEnd) begin
                        tcnt_d   = '0;
                        fe_acc_d = fe_now;
                        if (bcnt_q == LastStop) begin
                            bcnt_d  = '0;
                            data_d  = sh_q;
                            ferr_d  = fe_now;
                            perr_d  = pe_acc_q;
                            valid_d = 1'b1;
                            if (!fe_now && !pe_acc_q) ctrl_d = ~ctrl_q;
                            // A low final stop may be a break; wait for idle-high first.
                            state_d = rs_q ? StIdle : StWaitHigh;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                StWaitHigh: begin
                    if (rs_q) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign ctrl       = ctrl_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;

endmodule
